// File: rtl/vga_sync_gen_if.sv
// Video timing bundle: the generator drives position and sync, the consumer supplies the pixel tick.
interface vga_sync_gen_if;
   logic        en;
   logic        h_sync;
   logic        v_sync;
   logic        disp_active;
   logic [11:0] col_count;
   logic [11:0] row_count;
   logic        line_start;
   logic        frame_start;

   modport master (
      input  en,
      output h_sync, v_sync, disp_active, col_count, row_count, line_start, frame_start
   );

   modport slave (
      output en,
      input  h_sync, v_sync, disp_active, col_count, row_count, line_start, frame_start
   );
endinterface

// File: rtl/vga_sync_gen.sv
// Raster position counter with registered sync/blank decode; every output describes the
// position presented in the same cycle because the decode works from the next position.
module vga_sync_gen #(
   parameter int TOTAL_COLS    = 800,
   parameter int TOTAL_ROWS    = 525,
   parameter int DISP_COLS     = 640,
   parameter int DISP_ROWS     = 480,
   parameter int H_FRONT_PORCH = 16,
   parameter int H_BACK_PORCH  = 48,
   parameter int V_FRONT_PORCH = 10,
   parameter int V_BACK_PORCH  = 33
) (
   input  logic          clk,
   input  logic          rst,
   vga_sync_gen_if.master vga
);

   localparam int H_SYNC_W = TOTAL_COLS - DISP_COLS - H_FRONT_PORCH - H_BACK_PORCH;
   localparam int V_SYNC_W = TOTAL_ROWS - DISP_ROWS - V_FRONT_PORCH - V_BACK_PORCH;

   if (TOTAL_COLS > 4096 || TOTAL_ROWS > 4096) begin : g_bad_total
      $error("vga_sync_gen: TOTAL_COLS and TOTAL_ROWS must not exceed 4096");
   end
   if (H_SYNC_W < 1 || V_SYNC_W < 1) begin : g_bad_sync
      $error("vga_sync_gen: porches leave no room for a sync pulse");
   end

   localparam logic [11:0] COL_LAST = 12'(TOTAL_COLS - 1);
   localparam logic [11:0] ROW_LAST = 12'(TOTAL_ROWS - 1);
   localparam logic [12:0] H_DISP   = 13'(DISP_COLS);
   localparam logic [12:0] V_DISP   = 13'(DISP_ROWS);
   localparam logic [12:0] HS_BEGIN = 13'(DISP_COLS + H_FRONT_PORCH);
   localparam logic [12:0] HS_END   = 13'(DISP_COLS + H_FRONT_PORCH + H_SYNC_W);
   localparam logic [12:0] VS_BEGIN = 13'(DISP_ROWS + V_FRONT_PORCH);
   localparam logic [12:0] VS_END   = 13'(DISP_ROWS + V_FRONT_PORCH + V_SYNC_W);

   logic [11:0] col_q, row_q;
   logic [11:0] col_nxt, row_nxt;
   logic [12:0] col_ext, row_ext;
   logic        h_sync_q, v_sync_q, disp_q, line_q, frame_q;
   logic        h_sync_nxt, v_sync_nxt, disp_nxt;

   always_comb begin
      // NOTE: every signal gets a value before any branch, so no path can infer a latch.
      col_nxt = col_q + 12'd1;
      row_nxt = row_q;
      if (col_q == COL_LAST) begin
         col_nxt = '0;
         row_nxt = (row_q == ROW_LAST) ? '0 : row_q + 12'd1;
      end
   end

   // Decode the position about to be loaded so the flops land in step with the counters.
   always_comb begin
      col_ext    = {1'b0, col_nxt};
      row_ext    = {1'b0, row_nxt};
      h_sync_nxt = !(col_ext >= HS_BEGIN && col_ext < HS_END);
      v_sync_nxt = !(row_ext >= VS_BEGIN && row_ext < VS_END);
      disp_nxt   = (col_ext < H_DISP) && (row_ext < V_DISP);
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      if (rst) begin
         col_q    <= COL_LAST;
         row_q    <= ROW_LAST;
         h_sync_q <= 1'b1;
         v_sync_q <= 1'b1;
         disp_q   <= 1'b0;
         line_q   <= 1'b0;
         frame_q  <= 1'b0;
      end else if (vga.en) begin
         col_q    <= col_nxt;
         row_q    <= row_nxt;
         h_sync_q <= h_sync_nxt;
         v_sync_q <= v_sync_nxt;
         disp_q   <= disp_nxt;
         line_q   <= (col_nxt == '0);
         frame_q  <= (col_nxt == '0) && (row_nxt == '0);
      end else begin
         line_q   <= 1'b0;
         frame_q  <= 1'b0;
      end
   end

   assign vga.col_count   = col_q;
   assign vga.row_count   = row_q;
   assign vga.h_sync      = h_sync_q;
   assign vga.v_sync      = v_sync_q;
   assign vga.disp_active = disp_q;
   assign vga.line_start  = line_q;
   assign vga.frame_start = frame_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench: default 640x480 timing plus a tiny raster that wraps frames quickly,
// both compared every cycle against a linear-position reference model.
module tb_vga_sync_gen;

   localparam int A_TC = 800, A_TR = 525, A_DC = 640, A_DR = 480;
   localparam int A_HFP = 16, A_HBP = 48, A_VFP = 10, A_VBP = 33;
   localparam int B_TC = 10, B_TR = 8, B_DC = 4, B_DR = 4;
   localparam int B_HFP = 1, B_HBP = 2, B_VFP = 1, B_VBP = 1;

   typedef enum int {PH_RST, PH_ONE, PH_CONST, PH_TOGGLE, PH_RAND} phase_t;

   typedef struct packed {
      logic [11:0] col;
      logic [11:0] row;
      logic        hs;
      logic        vs;
      logic        da;
      logic        ls;
      logic        fs;
   } obs_t;

   logic clk = 1'b0;
   logic rst;
   vga_sync_gen_if bus_a ();
   vga_sync_gen_if bus_b ();

   vga_sync_gen u_dut_a (.clk(clk), .rst(rst), .vga(bus_a));

   vga_sync_gen #(
      .TOTAL_COLS(B_TC), .TOTAL_ROWS(B_TR), .DISP_COLS(B_DC), .DISP_ROWS(B_DR),
      .H_FRONT_PORCH(B_HFP), .H_BACK_PORCH(B_HBP), .V_FRONT_PORCH(B_VFP), .V_BACK_PORCH(B_VBP)
   ) u_dut_b (.clk(clk), .rst(rst), .vga(bus_b));

   always #5 clk = ~clk;

   int     checks = 0;
   int     errors = 0;
   obs_t   q_a[$];
   obs_t   q_b[$];
   phase_t phase = PH_RST;
   int     pa = A_TC * A_TR - 1;
   int     pb = B_TC * B_TR - 1;

   // Position is a single index into the frame; column/row and all flags follow by arithmetic.
   function automatic obs_t model(int p, bit adv, int tc, int tr, int dc, int dr,
                                  int hfp, int hbp, int vfp, int vbp);
      obs_t o;
      int col, row, hsw, vsw;
      col   = p % tc;
      row   = p / tc;
      hsw   = tc - dc - hfp - hbp;
      vsw   = tr - dr - vfp - vbp;
      o.col = 12'(col);
      o.row = 12'(row);
      o.hs  = !(col >= dc + hfp && col < dc + hfp + hsw);
      o.vs  = !(row >= dr + vfp && row < dr + vfp + vsw);
      o.da  = (col < dc) && (row < dr);
      o.ls  = adv && (col == 0);
      o.fs  = adv && (p == 0);
      return o;
   endfunction

   task automatic check_obs(input string name, input obs_t act, input obs_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t got col=%0d row=%0d hs=%b vs=%b da=%b ls=%b fs=%b want col=%0d row=%0d hs=%b vs=%b da=%b ls=%b fs=%b",
                  name, $time, act.col, act.row, act.hs, act.vs, act.da, act.ls, act.fs,
                  exp.col, exp.row, exp.hs, exp.vs, exp.da, exp.ls, exp.fs);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s t=%0t got %0d want %0d", name, $time, act, exp);
      end
   endtask

   task automatic step(input bit r, input bit e, input phase_t ph);
      bit adv;
      phase     = ph;
      rst       = r;
      bus_a.en  = e;
      bus_b.en  = e;
      adv       = 1'b0;
      if (r) begin
         pa = A_TC * A_TR - 1;
         pb = B_TC * B_TR - 1;
      end else if (e) begin
         pa  = (pa + 1) % (A_TC * A_TR);
         pb  = (pb + 1) % (B_TC * B_TR);
         adv = 1'b1;
      end
      q_a.push_back(model(pa, adv, A_TC, A_TR, A_DC, A_DR, A_HFP, A_HBP, A_VFP, A_VBP));
      q_b.push_back(model(pb, adv, B_TC, B_TR, B_DC, B_DR, B_HFP, B_HBP, B_VFP, B_VBP));
      @(negedge clk);
   endtask

   // Monitor: one observation per edge from each DUT, plus pulse-spacing checks in steady phases.
   initial begin
      int     cyc = 0;
      int     last_ls_a = 0, last_fs_b = 0, hl_cnt = 0;
      bit     v_ls_a = 0, v_fs_b = 0, v_hl = 0;
      phase_t tr_phase = PH_RST;
      obs_t   act_a, act_b;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         act_a = {bus_a.col_count, bus_a.row_count, bus_a.h_sync, bus_a.v_sync,
                  bus_a.disp_active, bus_a.line_start, bus_a.frame_start};
         act_b = {bus_b.col_count, bus_b.row_count, bus_b.h_sync, bus_b.v_sync,
                  bus_b.disp_active, bus_b.line_start, bus_b.frame_start};
         if (q_a.size() == 0 || q_b.size() == 0) begin
            check_int("scoreboard_underflow", 0, 1);
         end else begin
            check_obs("dut_a_default", act_a, q_a.pop_front());
            check_obs("dut_b_small", act_b, q_b.pop_front());
         end
         if (phase != tr_phase) begin
            v_ls_a   = 0;
            v_fs_b   = 0;
            v_hl     = 0;
            tr_phase = phase;
         end
         if (phase == PH_CONST || phase == PH_TOGGLE) begin
            if (act_a.ls) begin
               if (v_ls_a)
                  check_int("line_start_period_a", cyc - last_ls_a,
                            (phase == PH_CONST) ? A_TC : 2 * A_TC);
               if (v_hl && phase == PH_CONST)
                  check_int("h_sync_low_width_a", hl_cnt, 96);
               last_ls_a = cyc;
               v_ls_a    = 1;
               hl_cnt    = 0;
               v_hl      = 1;
            end
            if (!act_a.hs) hl_cnt++;
            if (act_b.fs) begin
               if (v_fs_b)
                  check_int("frame_start_period_b", cyc - last_fs_b,
                            (phase == PH_CONST) ? B_TC * B_TR : 2 * B_TC * B_TR);
               last_fs_b = cyc;
               v_fs_b    = 1;
            end
         end
      end
   end

   initial begin
      rst      = 1'b1;
      bus_a.en = 1'b0;
      bus_b.en = 1'b0;
      for (int i = 0; i < 3; i++) step(1'b1, (i == 1), PH_RST);
      step(1'b0, 1'b0, PH_RST);
      step(1'b0, 1'b1, PH_ONE);
      for (int i = 0; i < 2500; i++) step(1'b0, 1'b1, PH_CONST);
      step(1'b1, 1'b1, PH_RST);
      step(1'b0, 1'b0, PH_ONE);
      step(1'b0, 1'b1, PH_ONE);
      for (int i = 0; i < 3400; i++) step(1'b0, (i % 2 == 0), PH_TOGGLE);
      for (int i = 0; i < 6000; i++)
         step(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0), PH_RAND);
      check_int("scoreboard_drained", q_a.size() + q_b.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
